// File: rtl/led_disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment history display.
// The glyph table maps a 4-bit hex value to {g,f,e,d,c,b,a} with a on bit 0.
package led_disp_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] hex_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // Index 15 is leftmost, so glyph F comes first and glyph 0 last.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t hex_glyph(input hex_t h);
    return GLYPH_TABLE[h];
  endfunction

endpackage

// File: rtl/led_disp_if.sv
// Key input and display drive bundle between the panel logic and the LED matrix.
// The slave side is the driver block; the master side supplies key and watches the display.
interface led_disp_if;
  import led_disp_pkg::*;

  hex_t        key;
  logic [7:0]  select;
  seg_t        segment7x;
  logic        dp;

  modport master (output key, input select, input segment7x, input dp);
  modport slave  (input key, output select, output segment7x, output dp);

endinterface

// File: rtl/led_disp_hex_to_seg7.sv
// Combinational hex-to-glyph decoder for one 7-segment digit.
module hex_to_seg7
  import led_disp_pkg::*;
(
  input  hex_t hex_i,
  output seg_t seg_o
);

  always_comb begin
    seg_o = hex_glyph(hex_i);
  end

endmodule

// File: rtl/led_disp.sv
// 8-digit multiplexed 7-segment driver showing the last 8 distinct key values,
// newest on digit 0, with a decimal point marking the newest entry.
module led_disp
  import led_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 4,
  parameter int NUM_DIGITS = led_disp_pkg::NUM_DIGITS
) (
  input  logic        clk,
  input  logic        rst,
  led_disp_if.slave   bus
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  hex_t             sync1_q, sync1_d;
  hex_t             sync2_q, sync2_d;
  logic [1:0]       sync_vld_q, sync_vld_d;
  hex_t             pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  hex_t             hist_q [NUM_DIGITS];
  hex_t             hist_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       select_q, select_d;
  seg_t             seg_q, seg_d;
  logic             dp_q, dp_d;

  hex_t             ref_val;
  logic             ref_vld;
  logic             scan_tc;
  seg_t             glyph;

  hex_to_seg7 u_hex_to_seg7 (
    .hex_i (hist_q[idx_q]),
    .seg_o (glyph)
  );

  always_comb begin
    sync1_d    = bus.key;
    sync2_d    = sync1_q;
    // Valid bits keep reset-time contents of the synchroniser from being loaded.
    sync_vld_d = {sync_vld_q[0], 1'b1};

    // A pending load has not reached entry 0 yet, so compare against it instead.
    ref_val    = pend_q ? pend_val_q : hist_q[0];
    ref_vld    = pend_q | valid_q[0];
    pend_d     = sync_vld_q[1] && (!ref_vld || (sync2_q != ref_val));
    pend_val_d = sync2_q;

    hist_d  = hist_q;
    valid_d = valid_q;
    if (pend_q) begin
      hist_d[0] = pend_val_q;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        hist_d[i] = hist_q[i-1];
      end
      valid_d = {valid_q[NUM_DIGITS-2:0], 1'b1};
    end

    scan_tc = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d   = scan_tc ? '0 : cnt_q + 1'b1;
    idx_d   = scan_tc ? idx_q + 3'd1 : idx_q;

    select_d = ~(8'b1 << idx_q);
    seg_d    = valid_q[idx_q] ? glyph : SEG_BLANK;
    dp_d     = (idx_q == 3'd0) && valid_q[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync_vld_q <= '0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist_q[i] <= '0;
      end
      valid_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      select_q   <= 8'hFF;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync_vld_q <= sync_vld_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      hist_q     <= hist_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      select_q   <= select_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign bus.select    = select_q;
  assign bus.segment7x = seg_q;
  assign bus.dp        = dp_q;

endmodule

// File: tb/tb_led_disp.sv
// Bench for led_disp: key history frames, scan order/timing and reset behaviour.
module tb_led_disp;

  typedef logic [7:0][6:0] frame_t;
  typedef struct {
    logic [3:0] key;
    int         hold;
    frame_t     exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_disp_if bus ();

  led_disp #(.SCAN_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs [20];
  vec_t exp_q [$];

  function automatic frame_t mkf(input logic [6:0] a0, a1, a2, a3, a4, a5, a6, a7);
    frame_t f;
    f[0] = a0; f[1] = a1; f[2] = a2; f[3] = a3;
    f[4] = a4; f[5] = a5; f[6] = a6; f[7] = a7;
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Watch 40 cycles (more than one full scan) and record what each digit showed.
  task automatic capture(output frame_t seg, output logic [7:0] dpv, output int sel_errs);
    seg      = 'x;
    dpv      = 'x;
    sel_errs = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if ($countones(~bus.select) == 1) begin
        for (int d = 0; d < 8; d++) begin
          if (!bus.select[d]) begin
            seg[d] = bus.segment7x;
            dpv[d] = bus.dp;
          end
        end
      end else begin
        sel_errs++;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    frame_t     fr;
    logic [7:0] dpv;
    int         se;
    vec_t       e;
    bus.key = v.key;
    exp_q.push_back(v);
    cyc(v.hold);
    capture(fr, dpv, se);
    e = exp_q.pop_front();
    for (int d = 0; d < 8; d++) begin
      chk($sformatf("%s_digit%0d", tag, d), 64'(fr[d]), 64'(e.exp[d]));
    end
    chk($sformatf("%s_dp", tag), 64'(dpv), 64'h01);
    chk($sformatf("%s_onehot", tag), 64'(se), 64'd0);
    $display("vec %s key=%h frame d0..d7=%h %h %h %h %h %h %h %h", tag, v.key,
             fr[0], fr[1], fr[2], fr[3], fr[4], fr[5], fr[6], fr[7]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev_sel, s;
    int         found, run, runs, oh_err, ord_err, rl_err, wraps;
    vec_t       vr;

    vecs[0]  = '{4'h0, 10, mkf(7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00)};
    vecs[1]  = '{4'h1, 10, mkf(7'h06, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00)};
    vecs[2]  = '{4'h2, 10, mkf(7'h5B, 7'h06, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00)};
    vecs[3]  = '{4'h3, 10, mkf(7'h4F, 7'h5B, 7'h06, 7'h3F, 7'h00, 7'h00, 7'h00, 7'h00)};
    vecs[4]  = '{4'hA, 10, mkf(7'h77, 7'h4F, 7'h5B, 7'h06, 7'h3F, 7'h00, 7'h00, 7'h00)};
    vecs[5]  = '{4'h5, 10, mkf(7'h6D, 7'h77, 7'h4F, 7'h5B, 7'h06, 7'h3F, 7'h00, 7'h00)};
    vecs[6]  = '{4'h6, 10, mkf(7'h7D, 7'h6D, 7'h77, 7'h4F, 7'h5B, 7'h06, 7'h3F, 7'h00)};
    vecs[7]  = '{4'h7, 10, mkf(7'h07, 7'h7D, 7'h6D, 7'h77, 7'h4F, 7'h5B, 7'h06, 7'h3F)};
    vecs[8]  = '{4'hF, 10, mkf(7'h71, 7'h07, 7'h7D, 7'h6D, 7'h77, 7'h4F, 7'h5B, 7'h06)};
    vecs[9]  = '{4'hF, 10, mkf(7'h71, 7'h07, 7'h7D, 7'h6D, 7'h77, 7'h4F, 7'h5B, 7'h06)};
    vecs[10] = '{4'h5, 10, mkf(7'h6D, 7'h71, 7'h07, 7'h7D, 7'h6D, 7'h77, 7'h4F, 7'h5B)};
    vecs[11] = '{4'h5, 200, mkf(7'h6D, 7'h71, 7'h07, 7'h7D, 7'h6D, 7'h77, 7'h4F, 7'h5B)};
    vecs[12] = '{4'h0, 10, mkf(7'h3F, 7'h6D, 7'h71, 7'h07, 7'h7D, 7'h6D, 7'h77, 7'h4F)};
    vecs[13] = '{4'h4, 10, mkf(7'h66, 7'h3F, 7'h6D, 7'h71, 7'h07, 7'h7D, 7'h6D, 7'h77)};
    vecs[14] = '{4'h8, 10, mkf(7'h7F, 7'h66, 7'h3F, 7'h6D, 7'h71, 7'h07, 7'h7D, 7'h6D)};
    vecs[15] = '{4'hB, 10, mkf(7'h7C, 7'h7F, 7'h66, 7'h3F, 7'h6D, 7'h71, 7'h07, 7'h7D)};
    vecs[16] = '{4'hC, 10, mkf(7'h39, 7'h7C, 7'h7F, 7'h66, 7'h3F, 7'h6D, 7'h71, 7'h07)};
    vecs[17] = '{4'hD, 10, mkf(7'h5E, 7'h39, 7'h7C, 7'h7F, 7'h66, 7'h3F, 7'h6D, 7'h71)};
    vecs[18] = '{4'hE, 10, mkf(7'h79, 7'h5E, 7'h39, 7'h7C, 7'h7F, 7'h66, 7'h3F, 7'h6D)};
    vecs[19] = '{4'h9, 10, mkf(7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00)};

    // Reset state.
    bus.key = 4'h0;
    rst     = 1'b1;
    cyc(3);
    chk("reset_select", 64'(bus.select), 64'hFF);
    chk("reset_segment", 64'(bus.segment7x), 64'h00);
    chk("reset_dp", 64'(bus.dp), 64'h0);
    $display("reset: select=%h segment7x=%h dp=%b", bus.select, bus.segment7x, bus.dp);

    // First key after reset reaches digit 0 with the decimal point.
    rst   = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      @(negedge clk);
      if (bus.select == 8'hFE && bus.segment7x == 7'h3F && bus.dp == 1'b1) found = 1;
    end
    chk("first_key_on_digit0", 64'(found), 64'd1);
    $display("first load: seen=%0d", found);

    for (int i = 0; i < 19; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Scan order and dwell over 64 cycles.
    @(negedge clk);
    prev_sel = bus.select;
    run = 1; runs = 0; oh_err = 0; ord_err = 0; rl_err = 0; wraps = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      s = bus.select;
      if ($countones(~s) != 1) oh_err++;
      if (s == prev_sel) begin
        run++;
      end else begin
        if (s != {prev_sel[6:0], prev_sel[7]}) ord_err++;
        if (prev_sel == 8'h7F && s == 8'hFE) wraps++;
        if (runs > 0 && run != 4) rl_err++;
        runs++;
        run      = 1;
        prev_sel = s;
      end
    end
    chk("scan_onehot", 64'(oh_err), 64'd0);
    chk("scan_order", 64'(ord_err), 64'd0);
    chk("scan_dwell4", 64'(rl_err), 64'd0);
    chk("scan_steps", 64'(runs >= 14), 64'd1);
    chk("scan_wrap", 64'(wraps >= 1), 64'd1);
    $display("scan: steps=%0d wraps=%0d onehot_err=%0d order_err=%0d dwell_err=%0d",
             runs, wraps, oh_err, ord_err, rl_err);

    // One-cycle reset in the middle of a scan.
    cyc(3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_select", 64'(bus.select), 64'hFF);
    chk("midrst_segment", 64'(bus.segment7x), 64'h00);
    chk("midrst_dp", 64'(bus.dp), 64'h0);
    $display("mid reset: select=%h segment7x=%h dp=%b", bus.select, bus.segment7x, bus.dp);
    rst = 1'b0;
    vr  = vecs[19];
    run_vec(vr, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
